mdu_sequencer: RTL and testbench

//  Multi-cycle multiply/divide sequencer owning the HI/LO register pair.

---
 rtl/mdu_sequencer_pkg.sv | 34 +++
 rtl/mdu_iter_step.sv | 46 ++++
 rtl/mdu_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mdu_sequencer_pkg : opcode/func constants and FSM states for the HI/LO unit
// Rev 1.0
// ----------------------------------------------------------------------------
package mdu_sequencer_pkg;

  localparam logic [5:0] R_FORM = 6'h00;
  localparam logic [5:0] MFHI   = 6'h10;
  localparam logic [5:0] MTHI   = 6'h11;
  localparam logic [5:0] MFLO   = 6'h12;
  localparam logic [5:0] MTLO   = 6'h13;
  localparam logic [5:0] MULT   = 6'h18;
  localparam logic [5:0] MULTU  = 6'h19;
  localparam logic [5:0] DIV    = 6'h1A;
  localparam logic [5:0] DIVU   = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_t;

  function automatic logic is_mdu_func(input logic [5:0] f);
    return (f == MULT) || (f == MULTU) || (f == DIV)  || (f == DIVU) ||
           (f == MTHI) || (f == MTLO)  || (f == MFHI) || (f == MFLO);
  endfunction

  function automatic logic is_signed_func(input logic [5:0] f);
    return (f == MULT) || (f == DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mdu_iter_step : one combinational shift-add (multiply) or restoring-divide step
// Rev 1.0
// ----------------------------------------------------------------------------
module mdu_iter_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] q_nxt
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shl;
  logic            w_ge;

  always_comb begin
    w_sum   = {1'b0, acc} + {1'b0, opnd};
    w_shl   = {acc, q[XLEN-1]};
    w_ge    = (w_shl >= {1'b0, opnd});
    acc_nxt = acc;
    q_nxt   = q;
    if (is_div) begin
      // Partial remainder always stays below the divisor, so XLEN bits suffice.
      if (w_ge) begin
        acc_nxt = w_shl[XLEN-1:0] - opnd;
        q_nxt   = {q[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt = w_shl[XLEN-1:0];
        q_nxt   = {q[XLEN-2:0], 1'b0};
      end
    end else begin
      if (q[0]) begin
        {acc_nxt, q_nxt} = {w_sum, q[XLEN-1:1]};
      end else begin
        {acc_nxt, q_nxt} = {1'b0, acc, q[XLEN-1:1]};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mdu_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mdu_sequencer : multi-cycle multiply/divide sequencer owning HI/LO
// Rev 1.0
// ----------------------------------------------------------------------------
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            issue_valid,
  input  logic [5:0]      op,
  input  logic [5:0]      func,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic            stall,
  output logic            busy,
  output logic [XLEN-1:0] mf_data,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            div_zero
);

  localparam int CNT_W = $clog2(XLEN);

  mdu_state_t        r_state;
  mdu_state_t        w_state_nxt;
  logic [XLEN-1:0]   r_acc;
  logic [XLEN-1:0]   r_q;
  logic [XLEN-1:0]   r_opnd;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_div;
  logic              r_neg_a;
  logic              r_neg_b;
  logic              r_dz;
  logic              r_div_zero;

  logic              w_mdu_op;
  logic              w_idle;
  logic              w_accept;
  logic              w_start_mul;
  logic              w_start_div;
  logic              w_rs_neg;
  logic              w_rt_neg;
  logic              w_rt_zero;
  logic [XLEN-1:0]   w_rs_mag;
  logic [XLEN-1:0]   w_rt_mag;
  logic [XLEN-1:0]   w_acc_step;
  logic [XLEN-1:0]   w_q_step;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;

  assign w_mdu_op    = issue_valid && (op == R_FORM) && is_mdu_func(func);
  assign w_idle      = (r_state == ST_IDLE);
  assign w_accept    = w_mdu_op && w_idle;
  assign w_start_mul = w_accept && ((func == MULT) || (func == MULTU));
  assign w_start_div = w_accept && ((func == DIV) || (func == DIVU));

  assign w_rs_neg  = is_signed_func(func) && rs_data[XLEN-1];
  assign w_rt_neg  = is_signed_func(func) && rt_data[XLEN-1];
  assign w_rt_zero = (rt_data == '0);
  assign w_rs_mag  = w_rs_neg ? -rs_data : rs_data;
  assign w_rt_mag  = w_rt_neg ? -rt_data : rt_data;

  // Magnitude results; signs are applied once in FIX. 0x80000000/-1 falls
  // out naturally: magnitude quotient 0x80000000 negates to itself.
  assign w_prod     = {r_acc, r_q};
  assign w_prod_fix = r_neg_a ? -w_prod : w_prod;
  assign w_quo_fix  = r_neg_a ? -r_q : r_q;
  assign w_rem_fix  = r_neg_b ? -r_acc : r_acc;

  mdu_iter_step #(
    .XLEN (XLEN)
  ) u_step (
    .is_div  (r_is_div),
    .acc     (r_acc),
    .q       (r_q),
    .opnd    (r_opnd),
    .acc_nxt (w_acc_step),
    .q_nxt   (w_q_step)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_div && w_rt_zero) begin
          w_state_nxt = ST_FIX;
        end else if (w_start_mul || w_start_div) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN:  if (r_cnt == CNT_W'(XLEN-1)) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_acc      <= '0;
      r_q        <= '0;
      r_opnd     <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_dz       <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_mul) begin
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= w_rt_mag;
            r_opnd   <= w_rs_mag;
            r_neg_a  <= w_rs_neg ^ w_rt_neg;
            r_neg_b  <= 1'b0;
          end else if (w_start_div) begin
            r_is_div <= 1'b1;
            r_dz     <= w_rt_zero;
            r_cnt    <= '0;
            // On divide-by-zero the raw dividend rides in acc straight to HI.
            r_acc    <= w_rt_zero ? rs_data : '0;
            r_q      <= w_rs_mag;
            r_opnd   <= w_rt_mag;
            r_neg_a  <= w_rs_neg ^ w_rt_neg;
            r_neg_b  <= w_rs_neg;
          end else if (w_accept && (func == MTHI)) begin
            r_hi <= rs_data;
          end else if (w_accept && (func == MTLO)) begin
            r_lo <= rs_data;
          end
        end
        ST_RUN: begin
          r_acc <= w_acc_step;
          r_q   <= w_q_step;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        ST_FIX: begin
          if (r_dz) begin
            r_lo       <= '1;
            r_hi       <= r_acc;
            r_div_zero <= 1'b1;
          end else if (r_is_div) begin
            r_lo       <= w_quo_fix;
            r_hi       <= w_rem_fix;
            r_div_zero <= 1'b0;
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = !w_idle;
  assign stall    = w_mdu_op && !w_idle;
  assign mf_data  = (func == MFHI) ? r_hi : r_lo;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign div_zero = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mdu_sequencer : vector table, corner sequences and randomized model check
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mdu_sequencer;

  localparam logic [5:0] T_RFORM = 6'h00;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam int         LAT     = 33;

  logic        CLK = 1'b0;
  logic        RST;
  logic        issue_valid;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;
  logic        busy;
  logic [31:0] mf_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int total = 0;
  int bad   = 0;

  mdu_sequencer #(.XLEN(32)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .issue_valid (issue_valid),
    .op          (op),
    .func        (func),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .stall       (stall),
    .busy        (busy),
    .mf_data     (mf_data),
    .hi          (hi),
    .lo          (lo),
    .div_zero    (div_zero)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] o, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    issue_valid = 1'b1;
    op          = o;
    func        = f;
    rs_data     = a;
    rt_data     = b;
  endtask

  // Called at a negedge with an instruction driven; returns once it is no
  // longer stalled (the next posedge accepts it).
  task automatic hold(input string nm, output int stalls);
    #1;
    stalls = 0;
    while (stall && stalls < 200) begin
      stalls++;
      @(posedge CLK);
      @(negedge CLK);
      #1;
    end
    if (stall) chk({nm, "_accept_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic accept();
    @(posedge CLK);
    @(negedge CLK);
    issue_valid = 1'b0;
  endtask

  task automatic wait_idle(output int edges);
    edges = 0;
    while (busy && edges < 200) begin
      @(posedge CLK);
      edges++;
      @(negedge CLK);
    end
  endtask

  task automatic run_op(input string tag, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int lat);
    int s;
    int e;
    drive(T_RFORM, fn, a, b);
    hold(tag, s);
    chk({tag, "_issue_stall"}, s, 0);
    accept();
    wait_idle(e);
    chk({tag, "_latency"}, e, lat);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    chk({tag, "_div_zero"}, div_zero, edz);
    drive(T_RFORM, F_MFHI, 32'd0, 32'd0);
    #1;
    chk({tag, "_mfhi"}, mf_data, ehi);
    drive(T_RFORM, F_MFLO, 32'd0, 32'd0);
    #1;
    chk({tag, "_mflo"}, mf_data, elo);
    chk({tag, "_mf_stall"}, stall, 1'b0);
    issue_valid = 1'b0;
  endtask

  // Reference: plain 64-bit arithmetic straight from the instruction semantics.
  function automatic void model(input logic [5:0] fn, input logic [31:0] a,
                                input logic [31:0] b, input logic dz_in,
                                output logic [31:0] eh, output logic [31:0] el,
                                output logic dz_out);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz_out = dz_in;
    eh = 32'd0;
    el = 32'd0;
    if (fn == F_MULT) begin
      p = sa * sb;
      eh = p[63:32];
      el = p[31:0];
    end else if (fn == F_MULTU) begin
      p = {32'd0, a} * {32'd0, b};
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 32'd0) begin
      el = 32'hFFFF_FFFF;
      eh = a;
      dz_out = 1'b1;
    end else begin
      if (fn == F_DIV) begin
        q = sa / sb;
        r = sa % sb;
      end else begin
        q = {32'd0, a} / {32'd0, b};
        r = {32'd0, a} % {32'd0, b};
      end
      el = q[31:0];
      eh = r[31:0];
      dz_out = 1'b0;
    end
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0:       v = 32'd0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'($urandom_range(1, 20));
      4:       v = -32'($urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int          s;
    int          e;
    logic        m_dz;
    logic        n_dz;
    logic [31:0] eh;
    logic [31:0] el;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fns[4];

    fns = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
    vecs[0]  = '{F_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, LAT};
    vecs[1]  = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, LAT};
    vecs[2]  = '{F_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, LAT};
    vecs[3]  = '{F_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        1'b0, LAT};
    vecs[4]  = '{F_DIV,   32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b1, 1};
    vecs[5]  = '{F_DIVU,  32'd9,         32'd3,        32'd0,         32'd3,         1'b0, LAT};
    vecs[6]  = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0, LAT};
    vecs[7]  = '{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        1'b0, LAT};
    vecs[8]  = '{F_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, LAT};
    vecs[9]  = '{F_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 1};
    vecs[10] = '{F_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,        32'd0,         1'b1, LAT};
    vecs[11] = '{F_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,        1'b0, LAT};

    RST = 1'b1; issue_valid = 1'b0; op = 6'd0; func = 6'd0; rs_data = '0; rt_data = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_div_zero", div_zero, 1'b0);
    drive(T_RFORM, F_MFHI, 32'd0, 32'd0);
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_mfhi", mf_data, 32'd0);

    // MTHI then MFHI the following cycle
    drive(T_RFORM, F_MTHI, 32'h1234, 32'd0);
    hold("mthi", s);
    chk("mthi_stall", s, 0);
    accept();
    drive(T_RFORM, F_MFHI, 32'd0, 32'd0);
    #1;
    chk("mfhi_stall", stall, 1'b0);
    chk("mfhi_data", mf_data, 32'h1234);
    issue_valid = 1'b0;

    // Reset held two cycles in the middle of a divide
    drive(T_RFORM, F_DIVU, 32'd100, 32'd7);
    hold("rstdiv", s);
    accept();
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("middiv_rst_busy", busy, 1'b0);
    chk("middiv_rst_hi", hi, 32'd0);
    chk("middiv_rst_lo", lo, 32'd0);
    repeat (40) @(posedge CLK);
    @(negedge CLK);
    chk("middiv_late_hi", hi, 32'd0);
    chk("middiv_late_lo", lo, 32'd0);
    chk("middiv_late_busy", busy, 1'b0);

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].fn, vecs[i].a, vecs[i].b,
             vecs[i].ehi, vecs[i].elo, vecs[i].edz, vecs[i].lat);
    end

    // MFLO issued one cycle into a MULT stalls until the result lands
    drive(T_RFORM, F_MULT, 32'hFFFF_FFFD, 32'd7);
    hold("mflo_mult", s);
    accept();
    @(posedge CLK);
    @(negedge CLK);
    drive(T_RFORM, F_MFLO, 32'd0, 32'd0);
    hold("mflo_dep", s);
    chk("mflo_dep_stalls", s, 32);
    chk("mflo_dep_data", mf_data, 32'hFFFF_FFEB);
    chk("mflo_dep_busy", busy, 1'b0);
    accept();

    // Non-MDU instructions never stall; MTLO during RUN waits for IDLE
    drive(T_RFORM, F_MULTU, 32'd3, 32'd4);
    hold("mtlo_mul", s);
    accept();
    drive(T_RFORM, 6'h20, 32'd1, 32'd2);
    #1;
    chk("nonmdu_func_stall", stall, 1'b0);
    drive(6'h08, F_MULT, 32'd1, 32'd2);
    #1;
    chk("nonmdu_op_stall", stall, 1'b0);
    chk("run_busy", busy, 1'b1);
    issue_valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    drive(T_RFORM, F_MTLO, 32'hBEEF, 32'd0);
    hold("mtlo_run", s);
    chk("mtlo_run_stalls", s, 32);
    chk("mtlo_pre_lo", lo, 32'd12);
    accept();
    chk("mtlo_post_lo", lo, 32'hBEEF);
    chk("mtlo_post_hi", hi, 32'd0);

    // Back-to-back: second long op accepted in the first IDLE cycle
    drive(T_RFORM, F_MULT, 32'd6, 32'd7);
    hold("b2b_first", s);
    accept();
    drive(T_RFORM, F_DIVU, 32'd100, 32'd7);
    hold("b2b_second", s);
    chk("b2b_stalls", s, LAT);
    accept();
    chk("b2b_mid_lo", lo, 32'd42);
    chk("b2b_mid_hi", hi, 32'd0);
    wait_idle(e);
    chk("b2b_latency", e, LAT);
    chk("b2b_lo", lo, 32'd14);
    chk("b2b_hi", hi, 32'd2);

    // Randomized operations against the arithmetic model
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    m_dz = 1'b0;
    for (int i = 0; i < 150; i++) begin
      fn = fns[$urandom_range(0, 3)];
      a  = pick();
      b  = pick();
      model(fn, a, b, m_dz, eh, el, n_dz);
      run_op($sformatf("rnd%0d_f%h_a%h_b%h", i, fn, a, b), fn, a, b, eh, el, n_dz,
             ((fn == F_DIV || fn == F_DIVU) && b == 32'd0) ? 1 : LAT);
      m_dz = n_dz;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
